scan_counter: RTL

SCAN_COUNTER -- requirements
Module: scan_counter

---
 rtl/scan_counter_pkg.sv | 16 +
 rtl/scan_counter_rise_detect.sv | 31 +++
 rtl/scan_counter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/scan_counter_pkg.sv
// Shared display package: default panel geometry and the widths derived from it.
// Control and scan_counter both import this so they agree on panel geometry.
package scan_counter_pkg;

  // Pixels shifted per panel line.
  localparam int COLS_DEFAULT    = 64;
  // Scanned row pairs (HUB75 A-D address space).
  localparam int ROWS_DEFAULT    = 16;
  // Completed-frame counter width.
  localparam int FRAME_W_DEFAULT = 8;

  // Derived widths for the default geometry.
  localparam int COL_W_DEFAULT   = $clog2(COLS_DEFAULT);
  localparam int ROW_W_DEFAULT   = $clog2(ROWS_DEFAULT);

endpackage

// File: rtl/scan_counter_rise_detect.sv
// rise_detect: 1-bit registered rising-edge detector.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   din    - level input
//   rise   - high for the cycle in which din is high and was low on the previous clock
// After reset the detector stays disarmed until it has sampled din low at least once.
// A level held high across reset release therefore does not count as an edge.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic din,
  output logic rise
);

  logic prev_reg;
  logic armed_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      prev_reg  <= din;
      armed_reg <= armed_reg | ~din;
    end
  end

  assign rise = din & ~prev_reg & armed_reg;

endmodule

// File: rtl/scan_counter.sv
// scan_counter: column/row/frame sequencing for a HUB75-style LED panel.
// Ports:
//   i_clk, i_rst       - clock, asynchronous active-high reset
//   addColumns         - advance column counter by one (saturates at COLS)
//   rstColumns         - clear column counter (wins over addColumns)
//   addRow             - row-advance request, acted on at its rising edge
//   compColumns        - column counter == COLS (line fully shifted)
//   compRows           - last row advance wrapped the row counter to 0
//   o_col              - column index for pixel fetch (holds COLS-1 when saturated)
//   o_row_addr         - panel row address
//   o_frame            - completed-frame count (wraps)
//   o_frame_start      - one-cycle pulse after a row wrap
//   o_seq_err          - sticky: a row advance arrived before the line was complete
module scan_counter
  import scan_counter_pkg::*;
#(
  parameter int COLS    = COLS_DEFAULT,
  parameter int ROWS    = ROWS_DEFAULT,
  parameter int FRAME_W = FRAME_W_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     addColumns,
  input  logic                     rstColumns,
  input  logic                     addRow,
  output logic                     compColumns,
  output logic                     compRows,
  output logic [$clog2(COLS)-1:0]  o_col,
  output logic [$clog2(ROWS)-1:0]  o_row_addr,
  output logic [FRAME_W-1:0]       o_frame,
  output logic                     o_frame_start,
  output logic                     o_seq_err
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  // One extra bit so the counter can represent COLS itself (the "line done" state).
  localparam logic [COL_W:0]   COL_MAX  = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W:0]       col_reg,         col_next;
  logic [ROW_W-1:0]     row_reg,         row_next;
  logic [FRAME_W-1:0]   frame_reg,       frame_next;
  logic                 comp_rows_reg,   comp_rows_next;
  logic                 frame_start_reg, frame_start_next;
  logic                 seq_err_reg,     seq_err_next;

  logic                 row_rise;
  logic                 col_full;
  logic                 row_wrap;

  rise_detect u_row_rise (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .din   (addRow),
    .rise  (row_rise)
  );

  assign col_full = (col_reg == COL_MAX);
  assign row_wrap = (row_reg == ROW_LAST);

  always_comb begin
    col_next         = col_reg;
    row_next         = row_reg;
    frame_next       = frame_reg;
    comp_rows_next   = comp_rows_reg;
    frame_start_next = 1'b0;
    seq_err_next     = seq_err_reg;

    // Column path.
    if (rstColumns) begin
      col_next = '0;
    end else if (addColumns && !col_full) begin
      col_next = col_reg + 1'b1;
    end

    // Row path is independent of the column path; both act in the same cycle.
    if (row_rise) begin
      if (row_wrap) begin
        row_next         = '0;
        comp_rows_next   = 1'b1;
        frame_next       = frame_reg + 1'b1;
        frame_start_next = 1'b1;
      end else begin
        row_next         = row_reg + 1'b1;
        comp_rows_next   = 1'b0;
      end
      // Advancing the row with an unfinished line is flagged but still honoured.
      if (!col_full) begin
        seq_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_reg         <= '0;
      row_reg         <= '0;
      frame_reg       <= '0;
      comp_rows_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      seq_err_reg     <= 1'b0;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      frame_reg       <= frame_next;
      comp_rows_reg   <= comp_rows_next;
      frame_start_reg <= frame_start_next;
      seq_err_reg     <= seq_err_next;
    end
  end

  assign compColumns   = col_full;
  // Saturated counter's low bits would read 0, so hold the last valid index instead.
  assign o_col         = col_full ? COL_LAST : col_reg[COL_W-1:0];
  assign o_row_addr    = row_reg;
  assign o_frame       = frame_reg;
  assign compRows      = comp_rows_reg;
  assign o_frame_start = frame_start_reg;
  assign o_seq_err     = seq_err_reg;

endmodule
